keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Scans a 4x4 active-low matrix keypad and reports debounced presses as 4-bit hex codes 0..15.
- It is the input-side counterpart of the multiplexed hex display driver.
  - It drives one-hot column strobes in rotation, the same way the display walks its digit enables.
  - It decodes row returns back into the same 4-bit nibble space the display encodes.
- Its output feeds the data path that latches user-entered hex digits.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before its rows are sampled (dwell). Legal range is ≥2.
- DEBOUNCE_SCANS, 4: number of consecutive identical full scan frames required to accept a press or a release. Legal range is ≥1.
- REPEAT_FRAMES, 64: frames between auto-repeat strobes. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rows  input  4  keypad row returns, active-low, externally pulled up, asynchronous to clk.
- cols  output  4  column drive, active-low one-hot. Column c is driven when cols[c]=0.
- key  output  4  code of the last accepted key, = row*4 + col.
- key_valid  output  1  single-cycle strobe when a new press (or repeat) is accepted.
- key_held  output  1  high while an accepted key remains pressed.

Behaviour:
- Reset values (on a reset cycle): cols=4'b1110 (col 0), key=0, key_valid=0, key_held=0, all counters 0, FSM=IDLE.
- Synchronizer: rows passes through a 2-flop synchronizer (rows_s). It is inverted internally so that 1 = pressed.
- Dwell counter: counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1 (the sample tick), rows_s is recorded for the current column.
  - On the same tick, cols rotates left (1110→1101→1011→0111→1110) and the counter wraps to 0.
- Frame: closes on the sample tick of col 3. Frame result:
  - NONE: no bits set in any column.
  - SINGLE(code): exactly one bit set across all 16 positions. Code = row*4+col.
  - MULTI: two or more bits set. MULTI is treated as NONE for press acceptance. It does not release a PRESSED key (ghosting guard).
- Stability counter:
  - Increments when the frame result equals the previous frame result.
  - Reloads to 1 when it differs.
  - Saturates at DEBOUNCE_SCANS.
  - All compares use full result identity: kind plus code.
- FSM, evaluated only at frame close:
  - IDLE: result SINGLE(k) with stability==DEBOUNCE_SCANS → key<=k, key_valid=1 for the following cycle, key_held<=1, go PRESSED.
  - PRESSED, release: result NONE with stability==DEBOUNCE_SCANS → key_held<=0, go IDLE. key keeps its value.
  - PRESSED, different key: result SINGLE(j), j≠key, stable → treated as release then new press. key<=j, key_valid pulses, stay PRESSED.
  - PRESSED, MULTI or same key: hold.
- Latency: a clean press is accepted at the frame close that reaches DEBOUNCE_SCANS stable frames. key_valid asserts 1 cycle after that sample tick.
- key_valid is never high on two consecutive cycles.
- Reset mid-scan aborts the frame. The first frame after reset starts at col 0, dwell 0.
- A key held through reset is reported afresh after DEBOUNCE_SCANS frames.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In PRESSED, a frame counter counts stable frames of the same key.
  - Every REPEAT_FRAMES frames it pulses key_valid with key unchanged.
  - The counter clears on entry to PRESSED and on any key change.
- Undefined: exactly one key_valid per accepted press, and the REPEAT_FRAMES parameter is unused.

Test Plan:
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2. The bench models the keypad by pulling rows[r] low when cols[c]=0 and key (r,c) is down.
- Reset: assert reset 3 cycles → cols=1110, key=0, key_valid=0, key_held=0. Deassert → cols becomes 1101 after 4 cycles.
- Single press: hold key r=2,c=1 from time 0 → exactly one key_valid pulse with key=9. key_held=1 from frame 2 onward. Release: key_held=0 two stable frames later, key stays 9.
- Bounce: toggle key r=0,c=3 every frame for 6 frames, then hold → no key_valid during toggling. One pulse with key=3 after 2 stable frames.
- Ghosting: while key 5 is accepted, also press key 6 → no key_valid, key_held stays 1. Release key 5, keep 6 → key_valid with key=6.
- Reset mid-frame: press key 15, assert reset at dwell 2 of col 2 → outputs return to reset values. After release of reset, key_valid with key=15 within 2 frames plus synchronizer delay.
- Repeat (KEYPAD_REPEAT_EN, REPEAT_FRAMES=3): hold key 0 for 11 frames → pulses at acceptance then every 3 frames: 4 pulses total, all key=0. Without the macro, 1 pulse.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low keypad and reports debounced presses as hex codes.
// Define KEYPAD_REPEAT_EN to re-strobe key_valid every REPEAT_FRAMES frames while a key is held.
module keypad_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_FRAMES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
`ifdef KEYPAD_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  typedef enum logic {IDLE, PRESSED} state_t;
  typedef enum logic [1:0] {R_NONE, R_SINGLE, R_MULTI} kind_t;

  logic [3:0]    sync1_q, sync2_q, pressed;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   frame_q, frame_now;
  kind_t         prev_kind_q, res_kind;
  logic [3:0]    prev_code_q, res_code, enc;
  logic [SW-1:0] stab_q, stab_d, stab_next;
  state_t        state_q, state_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d, held_q, held_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          tick, frame_close, same, stable;

  assign pressed     = ~sync2_q;
  assign tick        = (dwell_q == DW'(SCAN_DIV - 1));
  assign frame_close = tick && (col_q == 2'd3);
  assign dwell_d     = tick ? '0 : dwell_q + DW'(1);
  assign col_d       = tick ? col_q + 2'd1 : col_q;
  assign cols        = ~(4'b0001 << col_q);
  assign key         = key_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;

  // Frame bit r*4+c holds row r of column c; the live column is merged in so the
  // col 3 sample counts toward the frame it closes.
  always_comb begin
    frame_now = frame_q;
    case (col_q)
      2'd0:    {frame_now[12], frame_now[8],  frame_now[4], frame_now[0]} = pressed;
      2'd1:    {frame_now[13], frame_now[9],  frame_now[5], frame_now[1]} = pressed;
      2'd2:    {frame_now[14], frame_now[10], frame_now[6], frame_now[2]} = pressed;
      default: {frame_now[15], frame_now[11], frame_now[7], frame_now[3]} = pressed;
    endcase
  end

  assign enc = {|(frame_now & 16'hFF00), |(frame_now & 16'hF0F0),
                |(frame_now & 16'hCCCC), |(frame_now & 16'hAAAA)};

  always_comb begin
    res_kind = R_MULTI;
    res_code = 4'd0;
    if (frame_now == 16'd0) begin
      res_kind = R_NONE;
    end else if ((frame_now & (frame_now - 16'd1)) == 16'd0) begin
      res_kind = R_SINGLE;
      res_code = enc;
    end
  end

  // Non-single results carry code 0, so kind+code equality is full result identity.
  assign same      = (res_kind == prev_kind_q) && (res_code == prev_code_q);
  assign stab_next = !same ? SW'(1) :
                     (stab_q == SW'(DEBOUNCE_SCANS)) ? stab_q : stab_q + SW'(1);
  assign stable    = (stab_next == SW'(DEBOUNCE_SCANS));

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
    stab_d  = stab_q;
    rpt_d   = rpt_q;
    if (frame_close) begin
      stab_d = stab_next;
      case (state_q)
        IDLE: begin
          if (res_kind == R_SINGLE && stable) begin
            key_d   = res_code;
            valid_d = 1'b1;
            held_d  = 1'b1;
            rpt_d   = '0;
            state_d = PRESSED;
          end
        end
        default: begin
          // MULTI frames never release: a ghosted chord keeps the accepted key held.
          if (res_kind == R_NONE && stable) begin
            held_d  = 1'b0;
            state_d = IDLE;
          end else if (res_kind == R_SINGLE && stable && res_code != key_q) begin
            key_d   = res_code;
            valid_d = 1'b1;
            rpt_d   = '0;
          end else if (RPT_ON && res_kind == R_SINGLE && res_code == key_q) begin
            if (rpt_q == RW'(REPEAT_FRAMES - 1)) begin
              valid_d = 1'b1;
              rpt_d   = '0;
            end else begin
              rpt_d = rpt_q + RW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    sync1_q <= rows;
    sync2_q <= sync1_q;
    if (tick) frame_q <= frame_now;
    if (reset) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      dwell_q     <= '0;
      col_q       <= 2'd0;
      prev_kind_q <= R_NONE;
      prev_code_q <= 4'd0;
      stab_q      <= '0;
      state_q     <= IDLE;
      key_q       <= 4'd0;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
      rpt_q       <= '0;
    end else begin
      dwell_q <= dwell_d;
      col_q   <= col_d;
      if (frame_close) begin
        prev_kind_q <= res_kind;
        prev_code_q <= res_code;
      end
      stab_q  <= stab_d;
      state_q <= state_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      rpt_q   <= rpt_d;
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, vector table, and a key_valid scoreboard.
module tb_keypad_scan;
  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int RF    = 3;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows, cols, key;
  logic        key_valid, key_held;
  logic [15:0] down = 16'd0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [3:0]  exp_q[$];

  typedef struct {
    logic [15:0] mask;
    int          frames;
    logic        pulse;
    logic [3:0]  pkey;
    logic        held;
    logic [3:0]  key;
    string       name;
  } vec_t;
  vec_t vecs[$];

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_FRAMES(RF)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Row r is pulled low when a down key in row r sits on a driven column.
  assign rows = {~|(down[15:12] & ~cols), ~|(down[11:8] & ~cols),
                 ~|(down[7:4] & ~cols),   ~|(down[3:0] & ~cols)};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic run_frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Scoreboard: every key_valid pulse must match the oldest expected key.
  initial begin
    logic       kv_prev;
    logic [3:0] e;
    kv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (key_valid) begin
        chk("kv_not_back_to_back", 16'(kv_prev), 16'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pulse: got key_valid with key=%0d, required no pulse", key);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_key", 16'(key), 16'(e));
        end
      end
      kv_prev = key_valid;
    end
  end

  initial begin
    vecs.push_back('{16'h0200, 1, 1'b0, 4'd0, 1'b0, 4'd0, "press9_f1"});
    vecs.push_back('{16'h0200, 1, 1'b1, 4'd9, 1'b1, 4'd9, "press9_acc"});
    vecs.push_back('{16'h0200, 2, 1'b0, 4'd0, 1'b1, 4'd9, "press9_hold"});
    vecs.push_back('{16'h0000, 1, 1'b0, 4'd0, 1'b1, 4'd9, "rel9_f1"});
    vecs.push_back('{16'h0000, 1, 1'b0, 4'd0, 1'b0, 4'd9, "rel9_acc"});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{(i % 2 == 0) ? 16'h0008 : 16'h0000, 1, 1'b0, 4'd0, 1'b0, 4'd9, "bounce3"});
    vecs.push_back('{16'h0008, 1, 1'b0, 4'd0, 1'b0, 4'd9, "b3_hold_f1"});
    vecs.push_back('{16'h0008, 1, 1'b1, 4'd3, 1'b1, 4'd3, "b3_acc"});
    vecs.push_back('{16'h0000, 2, 1'b0, 4'd0, 1'b0, 4'd3, "rel3"});
    vecs.push_back('{16'h0020, 2, 1'b1, 4'd5, 1'b1, 4'd5, "press5"});
    vecs.push_back('{16'h0060, 2, 1'b0, 4'd0, 1'b1, 4'd5, "ghost56"});
    vecs.push_back('{16'h0040, 2, 1'b1, 4'd6, 1'b1, 4'd6, "swap6"});
    vecs.push_back('{16'h0000, 2, 1'b0, 4'd0, 1'b0, 4'd6, "rel6"});

    // Reset values and first column step.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cols", 16'(cols), 16'hE);
    chk("rst_key", 16'(key), 16'h0);
    chk("rst_kv", 16'(key_valid), 16'h0);
    chk("rst_held", 16'(key_held), 16'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("cols_dwell3", 16'(cols), 16'hE);
    @(posedge clk);
    #1 chk("cols_step1", 16'(cols), 16'hD);

    do_reset();
    foreach (vecs[i]) begin
      down = vecs[i].mask;
      if (vecs[i].pulse) exp_q.push_back(vecs[i].pkey);
      run_frames(vecs[i].frames);
      chk({vecs[i].name, "_held"}, 16'(key_held), 16'(vecs[i].held));
      chk({vecs[i].name, "_key"}, 16'(key), 16'(vecs[i].key));
      chk({vecs[i].name, "_pending"}, 16'(exp_q.size()), 16'd0);
    end

    // Reset at dwell 2 of column 2 with key 15 held.
    down = 16'h8000;
    exp_q.push_back(4'd15);
    run_frames(2);
    chk("k15_held", 16'(key_held), 16'd1);
    chk("k15_key", 16'(key), 16'd15);
    repeat (2 * SD + 2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_cols", 16'(cols), 16'hE);
    chk("midrst_key", 16'(key), 16'h0);
    chk("midrst_held", 16'(key_held), 16'h0);
    chk("midrst_kv", 16'(key_valid), 16'h0);
    reset = 1'b0;
    exp_q.push_back(4'd15);
    run_frames(2);
    chk("after_rst_held", 16'(key_held), 16'd1);
    chk("after_rst_key", 16'(key), 16'd15);
    chk("after_rst_pending", 16'(exp_q.size()), 16'd0);

    // Hold key 0 for 11 frames.
    do_reset();
    down = 16'h0001;
`ifdef KEYPAD_REPEAT_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(4'd0);
`else
    exp_q.push_back(4'd0);
`endif
    run_frames(11);
    chk("rpt_held", 16'(key_held), 16'd1);
    chk("rpt_pending", 16'(exp_q.size()), 16'd0);
    down = 16'h0000;
    run_frames(2);
    chk("rpt_rel_held", 16'(key_held), 16'd0);
    chk("rpt_rel_pending", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
